// File: rtl/ysyx_axi_pkg.sv
// rtl/ysyx_axi_pkg.sv - shared AXI encodings, FSM state types and response merge
package ysyx_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Largest supported beat size: one 32-bit word.
    localparam logic [2:0] SIZE_MAX = 3'd2;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    // Severity order used when folding beat responses: DECERR > SLVERR > EXOKAY > OKAY.
    function automatic logic [1:0] resp_rank(input logic [1:0] resp);
        case (resp)
            RESP_DECERR: resp_rank = 2'd3;
            RESP_SLVERR: resp_rank = 2'd2;
            RESP_EXOKAY: resp_rank = 2'd1;
            default:     resp_rank = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        resp_merge = (resp_rank(b) > resp_rank(a)) ? b : a;
    endfunction

endpackage

// File: rtl/ysyx_axi_burst_addr.sv
// rtl/ysyx_axi_burst_addr.sv - burst next-address and window/request classification
//
// Purely combinational helper, one instance per channel.
//   addr/size/burst : current beat address and burst attributes
//   next_addr       : address of the following beat (FIXED holds, INCR adds 1<<size)
//   index           : scratchpad word index of addr
//   in_range        : addr falls inside [BASE_ADDR, BASE_ADDR + 4*DEPTH)
//   req_err         : burst type or size not supported (answered with SLVERR)
module ysyx_axi_burst_addr #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h0f00_0000,
    localparam int             IDX_W     = $clog2(DEPTH)
) (
    input  logic [XLEN-1:0]  addr,
    input  logic [2:0]       size,
    input  logic [1:0]       burst,
    output logic [XLEN-1:0]  next_addr,
    output logic [IDX_W-1:0] index,
    output logic             in_range,
    output logic             req_err
);
    import ysyx_axi_pkg::*;

    localparam logic [XLEN-1:0] WIN_BYTES = XLEN'(4 * DEPTH);

    logic [XLEN-1:0] offset;

    always_comb begin
        offset    = addr - BASE_ADDR;
        // The lower-bound test matters: below BASE_ADDR the subtraction wraps.
        in_range  = (addr >= BASE_ADDR) && (offset < WIN_BYTES);
        index     = offset[IDX_W+1:2];
        req_err   = !((burst == BURST_FIXED) || (burst == BURST_INCR)) || (size > SIZE_MAX);
        next_addr = (burst == BURST_INCR) ? (addr + (XLEN'(1) << size)) : addr;
    end

endmodule

// File: rtl/ysyx_axi_slave_sram.sv
// rtl/ysyx_axi_slave_sram.sv - AXI4 slave responder in front of a local scratchpad SRAM
//
// Ports:
//   clock, reset                       : single clock, synchronous active-high reset
//   ar*/arvalid/arready                : read address channel
//   rid/rdata/rresp/rlast/rvalid/rready: read data channel
//   aw*/awvalid/awready                : write address channel
//   wdata/wstrb/wlast/wvalid/wready    : write data channel
//   bid/bresp/bvalid/bready            : write response channel
// Read and write channels have independent FSMs and may run concurrently.
module ysyx_axi_slave_sram #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h0f00_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        arburst,
    input  logic [2:0]        arsize,
    input  logic [7:0]        arlen,
    input  logic [3:0]        arid,
    input  logic [XLEN-1:0]   araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic              rlast,
    output logic [XLEN-1:0]   rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic [1:0]        awburst,
    input  logic [2:0]        awsize,
    input  logic [7:0]        awlen,
    input  logic [3:0]        awid,
    input  logic [XLEN-1:0]   awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic              wlast,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN/8-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);
    import ysyx_axi_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB    = XLEN / 8;

    logic [XLEN-1:0] mem_q [DEPTH];

    // ---------------- read channel state ----------------
    r_state_t        r_state_q, r_state_d;
    logic [3:0]      r_id_q, r_id_d;
    logic [XLEN-1:0] r_addr_q, r_addr_d;
    logic [7:0]      r_len_q, r_len_d;
    logic [7:0]      r_cnt_q, r_cnt_d;
    logic [2:0]      r_size_q, r_size_d;
    logic [1:0]      r_burst_q, r_burst_d;
    logic            r_err_q, r_err_d;
    logic            r_fresh_q, r_fresh_d;
    logic [XLEN-1:0] r_hold_q, r_hold_d;

    logic [XLEN-1:0]  r_ba_addr, r_next_addr;
    logic [2:0]       r_ba_size;
    logic [1:0]       r_ba_burst, r_beat_resp;
    logic [IDX_W-1:0] r_index;
    logic             r_in_range, r_req_err;

    // While idle the helper classifies the incoming request; afterwards it
    // walks the latched burst.
    assign r_ba_addr  = (r_state_q == R_IDLE) ? araddr  : r_addr_q;
    assign r_ba_size  = (r_state_q == R_IDLE) ? arsize  : r_size_q;
    assign r_ba_burst = (r_state_q == R_IDLE) ? arburst : r_burst_q;

    ysyx_axi_burst_addr #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) u_r_addr (
        .addr      (r_ba_addr),
        .size      (r_ba_size),
        .burst     (r_ba_burst),
        .next_addr (r_next_addr),
        .index     (r_index),
        .in_range  (r_in_range),
        .req_err   (r_req_err)
    );

    always_comb begin
        r_state_d   = r_state_q;
        r_id_d      = r_id_q;
        r_addr_d    = r_addr_q;
        r_len_d     = r_len_q;
        r_cnt_d     = r_cnt_q;
        r_size_d    = r_size_q;
        r_burst_d   = r_burst_q;
        r_err_d     = r_err_q;
        r_fresh_d   = r_fresh_q;
        r_hold_d    = r_hold_q;
        arready     = 1'b0;
        rvalid      = 1'b0;
        rid         = 4'd0;
        rlast       = 1'b0;
        rresp       = RESP_OKAY;
        rdata       = '0;
        r_beat_resp = r_err_q ? RESP_SLVERR : (r_in_range ? RESP_OKAY : RESP_DECERR);

        case (r_state_q)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    r_id_d    = arid;
                    r_addr_d  = araddr;
                    r_len_d   = arlen;
                    r_size_d  = arsize;
                    r_burst_d = arburst;
                    r_err_d   = r_req_err;
                    r_cnt_d   = 8'd0;
                    r_fresh_d = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                rid    = r_id_q;
                rresp  = r_beat_resp;
                rlast  = (r_cnt_q == r_len_q);
                // The word is read live on the first cycle of a beat and then
                // frozen, so a write landing during a stall cannot disturb it.
                if (r_fresh_q) begin
                    rdata = (r_beat_resp == RESP_OKAY) ? mem_q[r_index] : '0;
                end else begin
                    rdata = r_hold_q;
                end
                if (rready) begin
                    if (rlast) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_addr_d  = r_next_addr;
                        r_fresh_d = 1'b1;
                    end
                end else begin
                    r_fresh_d = 1'b0;
                    r_hold_d  = rdata;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_id_q    <= 4'd0;
            r_addr_q  <= '0;
            r_len_q   <= 8'd0;
            r_cnt_q   <= 8'd0;
            r_size_q  <= 3'd0;
            r_burst_q <= 2'd0;
            r_err_q   <= 1'b0;
            r_fresh_q <= 1'b0;
            r_hold_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_err_q   <= r_err_d;
            r_fresh_q <= r_fresh_d;
            r_hold_q  <= r_hold_d;
        end
    end

    // ---------------- write channel state ----------------
    w_state_t        w_state_q, w_state_d;
    logic [3:0]      w_id_q, w_id_d;
    logic [XLEN-1:0] w_addr_q, w_addr_d;
    logic [7:0]      w_len_q, w_len_d;
    logic [7:0]      w_cnt_q, w_cnt_d;
    logic [2:0]      w_size_q, w_size_d;
    logic [1:0]      w_burst_q, w_burst_d;
    logic            w_err_q, w_err_d;
    logic            w_over_q, w_over_d;
    logic [1:0]      w_resp_q, w_resp_d;

    logic [XLEN-1:0]  w_ba_addr, w_next_addr;
    logic [2:0]       w_ba_size;
    logic [1:0]       w_ba_burst, w_beat_resp, w_fold;
    logic [IDX_W-1:0] w_index;
    logic             w_in_range, w_req_err, w_we, w_len_mismatch;

    assign w_ba_addr  = (w_state_q == W_IDLE) ? awaddr  : w_addr_q;
    assign w_ba_size  = (w_state_q == W_IDLE) ? awsize  : w_size_q;
    assign w_ba_burst = (w_state_q == W_IDLE) ? awburst : w_burst_q;

    ysyx_axi_burst_addr #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) u_w_addr (
        .addr      (w_ba_addr),
        .size      (w_ba_size),
        .burst     (w_ba_burst),
        .next_addr (w_next_addr),
        .index     (w_index),
        .in_range  (w_in_range),
        .req_err   (w_req_err)
    );

    always_comb begin
        w_state_d      = w_state_q;
        w_id_d         = w_id_q;
        w_addr_d       = w_addr_q;
        w_len_d        = w_len_q;
        w_cnt_d        = w_cnt_q;
        w_size_d       = w_size_q;
        w_burst_d      = w_burst_q;
        w_err_d        = w_err_q;
        w_over_d       = w_over_q;
        w_resp_d       = w_resp_q;
        awready        = 1'b0;
        wready         = 1'b0;
        bvalid         = 1'b0;
        bid            = 4'd0;
        bresp          = RESP_OKAY;
        w_we           = 1'b0;
        w_beat_resp    = w_err_q ? RESP_SLVERR : (w_in_range ? RESP_OKAY : RESP_DECERR);
        // wlast must coincide with beat number len; either mismatch is SLVERR.
        w_len_mismatch = (wlast != (w_cnt_q == w_len_q));
        w_fold         = resp_merge(w_resp_q, w_beat_resp);

        case (w_state_q)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) begin
                    w_id_d    = awid;
                    w_addr_d  = awaddr;
                    w_len_d   = awlen;
                    w_size_d  = awsize;
                    w_burst_d = awburst;
                    w_err_d   = w_req_err;
                    w_cnt_d   = 8'd0;
                    w_over_d  = 1'b0;
                    w_resp_d  = RESP_OKAY;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    if (!w_over_q) begin
                        w_we     = (w_beat_resp == RESP_OKAY);
                        w_resp_d = w_len_mismatch ? resp_merge(w_fold, RESP_SLVERR) : w_fold;
                        if (!wlast) begin
                            if (w_cnt_q == w_len_q) begin
                                // Past the announced length: drop beats until wlast.
                                w_over_d = 1'b1;
                            end else begin
                                w_cnt_d  = w_cnt_q + 8'd1;
                                w_addr_d = w_next_addr;
                            end
                        end
                    end
                    if (wlast) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                bid    = w_id_q;
                bresp  = w_resp_q;
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            w_id_q    <= 4'd0;
            w_addr_q  <= '0;
            w_len_q   <= 8'd0;
            w_cnt_q   <= 8'd0;
            w_size_q  <= 3'd0;
            w_burst_q <= 2'd0;
            w_err_q   <= 1'b0;
            w_over_q  <= 1'b0;
            w_resp_q  <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
            w_over_q  <= w_over_d;
            w_resp_q  <= w_resp_d;
        end
    end

    // Scratchpad storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (w_we) begin
            for (int i = 0; i < NB; i++) begin
                if (wstrb[i]) begin
                    mem_q[w_index][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
